// File: rtl/rd_pkg.sv
// rd_pkg: shared definitions for the read-side vector loader.
//   state_e      loader FSM states
//   *_DEF        default widths used as parameter defaults by rd_vec_loader
package rd_pkg;

    localparam int unsigned N_DEF     = 32;
    localparam int unsigned W_DEF     = 8;
    localparam int unsigned LANES_DEF = 4;
    localparam int unsigned LEN_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_e;

endpackage

// File: rtl/rd_addr_gen.sv
// rd_addr_gen: N-bit read-address counter.
//   clk, rst   clock, async active-high reset (clears addr)
//   load       synchronous load of load_val (priority over en)
//   load_val   value to load
//   en         increment by one, wrapping modulo 2^N
//   addr       current address
module rd_addr_gen #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         en,
    output logic [N-1:0] addr
);

    logic [N-1:0] addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
        end else if (load) begin
            addr_q <= load_val;
        end else if (en) begin
            addr_q <= addr_q + N'(1);
        end
    end

    assign addr = addr_q;

endmodule

// File: rtl/rd_vec_loader.sv
// rd_vec_loader: walks consecutive addresses, issues single-word reads to a
// 1-cycle-latency memory, packs LANES words into a vector and hands it out
// over a valid/ready handshake.
//   clk, rst            clock, async active-high reset
//   start               command strobe (only honoured in IDLE)
//   base_addr, num_vecs command operands, latched on accepted start
//   mem_addr, mem_re    read request; data returns on mem_rdata next cycle
//   mem_rdata           read data
//   vec_out, vec_valid  output vector (lane 0 = lowest address in low bits)
//   vec_ready           consumer ready
//   busy                FSM not idle
//   done                one-cycle pulse after the command completes
module rd_vec_loader
    import rd_pkg::*;
#(
    parameter int unsigned N     = N_DEF,
    parameter int unsigned W     = W_DEF,
    parameter int unsigned LANES = LANES_DEF,
    parameter int unsigned LEN_W = LEN_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N-1:0]       base_addr,
    input  logic [LEN_W-1:0]   num_vecs,
    output logic [N-1:0]       mem_addr,
    output logic               mem_re,
    input  logic [W-1:0]       mem_rdata,
    output logic [LANES*W-1:0] vec_out,
    output logic               vec_valid,
    input  logic               vec_ready,
    output logic               busy,
    output logic               done
);

    localparam int unsigned CW = $clog2(LANES + 1);

    state_e                    state_q, state_d;
    logic [CW-1:0]             iss_cnt_q, iss_cnt_d;
    logic [CW-1:0]             rcv_cnt_q, rcv_cnt_d;
    logic [LEN_W-1:0]          vecs_left_q, vecs_left_d;
    logic [LANES-1:0][W-1:0]   asm_q, asm_d;
    logic [LANES*W-1:0]        vec_q, vec_d;
    logic                      valid_q, valid_d;
    logic                      rd_pending_q;
    logic                      done_q, done_d;
    logic                      addr_load;
    logic                      hs;
    logic                      xfer;

    rd_addr_gen #(
        .N (N)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .load     (addr_load),
        .load_val (base_addr),
        .en       (mem_re),
        .addr     (mem_addr)
    );

    assign hs   = valid_q && vec_ready;
    // Output register is free when empty or being drained this cycle.
    assign xfer = (state_q == RUN) && (rcv_cnt_q == CW'(LANES)) && (!valid_q || vec_ready);

    always_comb begin
        state_d     = state_q;
        iss_cnt_d   = iss_cnt_q;
        rcv_cnt_d   = rcv_cnt_q;
        vecs_left_d = vecs_left_q;
        asm_d       = asm_q;
        vec_d       = vec_q;
        valid_d     = valid_q;
        done_d      = 1'b0;
        mem_re      = 1'b0;
        addr_load   = 1'b0;

        if (hs) begin
            valid_d = 1'b0;
        end

        if (rd_pending_q) begin
            for (int i = 0; i < LANES; i++) begin
                if (rcv_cnt_q == CW'(i)) begin
                    asm_d[i] = mem_rdata;
                end
            end
            rcv_cnt_d = rcv_cnt_q + CW'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_vecs != '0) begin
                        addr_load   = 1'b1;
                        vecs_left_d = num_vecs;
                        iss_cnt_d   = '0;
                        rcv_cnt_d   = '0;
                        state_d     = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (xfer) begin
                    vec_d       = asm_q;
                    valid_d     = 1'b1;
                    iss_cnt_d   = '0;
                    rcv_cnt_d   = '0;
                    vecs_left_d = vecs_left_q - LEN_W'(1);
                    if (vecs_left_q == LEN_W'(1)) begin
                        state_d = DRAIN;
                    end
                end else if ((iss_cnt_q < CW'(LANES)) && (vecs_left_q != '0)) begin
                    mem_re    = 1'b1;
                    iss_cnt_d = iss_cnt_q + CW'(1);
                end
            end
            DRAIN: begin
                if (hs) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            iss_cnt_q    <= '0;
            rcv_cnt_q    <= '0;
            vecs_left_q  <= '0;
            asm_q        <= '0;
            vec_q        <= '0;
            valid_q      <= 1'b0;
            rd_pending_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            iss_cnt_q    <= iss_cnt_d;
            rcv_cnt_q    <= rcv_cnt_d;
            vecs_left_q  <= vecs_left_d;
            asm_q        <= asm_d;
            vec_q        <= vec_d;
            valid_q      <= valid_d;
            rd_pending_q <= mem_re;
            done_q       <= done_d;
        end
    end

    assign vec_out   = vec_q;
    assign vec_valid = valid_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

endmodule
